// File: rtl/adder_seq_pkg.sv
// Shared types for the chunked sequential adder: FSM state encoding.
package adder_seq_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adder_seq_chunked_chunk_adder.sv
// Combinational CHUNK-bit ripple adder used as the narrow datapath slice.
// With ADDER_SEQ_OVERFLOW_EN defined it also exposes the carry into its MSB.
module chunk_adder #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
`ifdef ADDER_SEQ_OVERFLOW_EN
  ,
  output logic             co_msb_in
`endif
);

  // Ripple the carry bit by bit; the carry seen by the top bit is captured for overflow.
  always_comb begin
    logic c;
    c = ci;
    s = '0;
`ifdef ADDER_SEQ_OVERFLOW_EN
    co_msb_in = 1'b0;
`endif
    for (int i = 0; i < CHUNK; i++) begin
`ifdef ADDER_SEQ_OVERFLOW_EN
      if (i == CHUNK - 1) begin
        co_msb_in = c;
      end
`endif
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule

// File: rtl/adder_seq_chunked.sv
// Multi-cycle adder: {Cout,S} = A + B + Cin, CHUNK bits per clock, valid/ready on both sides.
// Optional macro ADDER_SEQ_OVERFLOW_EN adds a registered signed-overflow output Ovf.
module adder_seq_chunked
  import adder_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout
`ifdef ADDER_SEQ_OVERFLOW_EN
  ,
  output logic             Ovf
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_badChunk
    $error("adder_seq_chunked: WIDTH (%0d) must be a multiple of CHUNK (%0d)", WIDTH, CHUNK);
  end

  state_t             r_state;
  state_t             w_nextState;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sum;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  logic [CHUNK-1:0]   w_chunkSum;
  logic               w_chunkCo;
  logic [WIDTH-1:0]   w_sumNext;
  logic               w_lastChunk;
  logic               w_accept;

  assign w_accept    = in_valid && (r_state == IDLE);
  assign w_lastChunk = (r_cnt == CNT_W'(NCHUNK - 1));

`ifdef ADDER_SEQ_OVERFLOW_EN
  logic w_coMsbIn;
  logic r_ovf;
`endif

  chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunkAdder (
    .a         (r_a[CHUNK-1:0]),
    .b         (r_b[CHUNK-1:0]),
    .ci        (r_carry),
    .s         (w_chunkSum),
    .co        (w_chunkCo)
`ifdef ADDER_SEQ_OVERFLOW_EN
    ,
    .co_msb_in (w_coMsbIn)
`endif
  );

  // Each chunk result enters at the top, so after NCHUNK steps chunk 0 sits at the bottom.
  if (CHUNK == WIDTH) begin : g_singleChunk
    assign w_sumNext = w_chunkSum;
  end else begin : g_multiChunk
    assign w_sumNext = {w_chunkSum, r_sum[WIDTH-1:CHUNK]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_nextState = RUN;
      RUN:     if (w_lastChunk) w_nextState = DONE;
      DONE:    if (out_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Result is only exposed in DONE so a partially accumulated sum never leaks out.
  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
    S         = (r_state == DONE) ? r_sum : '0;
    Cout      = (r_state == DONE) ? r_carry : 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a     <= A;
            r_b     <= B;
            r_sum   <= '0;
            r_carry <= Cin;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_a     <= r_a >> CHUNK;
          r_b     <= r_b >> CHUNK;
          r_sum   <= w_sumNext;
          r_carry <= w_chunkCo;
          r_cnt   <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef ADDER_SEQ_OVERFLOW_EN
  // Signed overflow is the disagreement between carry into and out of the final MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_ovf <= 1'b0;
    end else if ((r_state == RUN) && w_lastChunk) begin
      r_ovf <= w_chunkCo ^ w_coMsbIn;
    end
  end

  assign Ovf = r_ovf;
`endif

endmodule
